// File: rtl/fp_pkg.sv
// Shared IEEE-754 helpers for the pipelined floating-point add/subtract unit.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
// Contents: field extraction for any exponent/mantissa split, operand class
// enum, flag bit positions, canonical quiet NaN and exponent bias.
package fp_pkg;

  // Widest supported word (double precision); narrower formats zero-extend.
  localparam int FP_MAXW = 64;
  typedef logic [FP_MAXW-1:0] fp_word_t;

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    NORM = 2'd1,
    INF  = 2'd2,
    NAN  = 2'd3
  } fp_class_e;

  // Bit positions inside the 4-bit flags word {invalid, overflow, underflow, inexact}.
  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  function automatic logic fp_sign(input fp_word_t w, input int e, input int m);
    fp_word_t t;
    t = w >> (e + m);
    return t[0];
  endfunction

  function automatic fp_word_t fp_exp(input fp_word_t w, input int e, input int m);
    return (w >> m) & ((64'd1 << e) - 64'd1);
  endfunction

  function automatic fp_word_t fp_frac(input fp_word_t w, input int m);
    return w & ((64'd1 << m) - 64'd1);
  endfunction

  function automatic fp_word_t fp_bias(input int e);
    return (64'd1 << (e - 1)) - 64'd1;
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB set.
  function automatic fp_word_t fp_qnan(input int e, input int m);
    return (((64'd1 << e) - 64'd1) << m) | (64'd1 << (m - 1));
  endfunction

  // Exponent 0 is always zero: subnormal fractions are flushed.
  function automatic fp_class_e fp_class(input fp_word_t w, input int e, input int m);
    fp_word_t ex;
    ex = fp_exp(w, e, m);
    if (ex == '0) return ZERO;
    if (ex == ((64'd1 << e) - 64'd1)) return (fp_frac(w, m) == '0) ? INF : NAN;
    return NORM;
  endfunction

endpackage

// File: rtl/fp_addsub_pipe_if.sv
// Operand/result bundle for the pipelined floating-point add/subtract unit.
// Latency: none (wires only).
// Backpressure: valid/ready on both the operand and the result side.
// master: drives operands and out_ready; slave: the adder itself.
interface fp_addsub_pipe_if #(
  parameter int exponent = 8,
  parameter int mantissa = 23
);
  localparam int W = exponent + mantissa + 1;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] input1;
  logic [W-1:0] input2;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic [3:0]   flags;

  modport master (
    output in_valid, input1, input2, sub, out_ready,
    input  in_ready, out_valid, out, flags
  );

  modport slave (
    input  in_valid, input1, input2, sub, out_ready,
    output in_ready, out_valid, out, flags
  );
endinterface

// File: rtl/fp_lzc.sv
// Priority leading-zero counter; an all-zero vector returns WIDTH.
// Latency: combinational.
// Backpressure: not applicable.
// Ports: vec_i (vector to scan, MSB first), cnt_o (number of leading zeros).
module fp_lzc #(
  parameter int WIDTH = 27
) (
  input  logic [WIDTH-1:0]             vec_i,
  output logic [$clog2(WIDTH+1)-1:0]   cnt_o
);
  localparam int CW = $clog2(WIDTH + 1);

  // Scanning upward lets the highest set bit win the last assignment.
  always_comb begin
    cnt_o = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (vec_i[i]) cnt_o = CW'(WIDTH - 1 - i);
    end
  end
endmodule

// File: rtl/fp_addsub_pipe.sv
// Pipelined IEEE-754 add/subtract, round-to-nearest-even, subnormals flushed to zero.
// Latency: 3 cycles (align / add / normalise-round-pack), one operand pair per cycle.
// Backpressure: all stages advance together only when the output slot is free or taken.
// Ports: clk, rst (sync, active high), fp_if slave: in_valid/in_ready/input1/input2/sub,
// out_valid/out_ready/out/flags {invalid, overflow, underflow, inexact}.
module fp_addsub_pipe
  import fp_pkg::*;
#(
  parameter int exponent = 8,
  parameter int mantissa = 23
) (
  input logic             clk,
  input logic             rst,
  fp_addsub_pipe_if.slave fp_if
);
  localparam int E    = exponent;
  localparam int M    = mantissa;
  localparam int W    = E + M + 1;
  localparam int F    = M + 4;              // hidden, fraction, guard, round, sticky
  localparam int LZW  = $clog2(F + 1);
  localparam int EMAX = (1 << E) - 1;
  localparam logic [W-1:0] QNAN = W'(fp_qnan(E, M));

  logic adv;
  logic out_valid_q;
  logic [W-1:0] out_q;
  logic [3:0] flags_q;

  assign adv             = !out_valid_q | fp_if.out_ready;
  assign fp_if.in_ready  = adv & ~rst;
  assign fp_if.out_valid = out_valid_q;
  assign fp_if.out       = out_q;
  assign fp_if.flags     = flags_q;

  // ---------------- stage 1: unpack, swap, align ----------------
  logic [W-1:0] a_w, b_w, big_w;
  logic         a_s, b_s, big_s, sml_s;
  logic [E-1:0] a_e, b_e, big_e, sml_e;
  logic [M-1:0] a_f, b_f, big_f, sml_f;
  fp_class_e    a_c, b_c;
  logic [W-2:0] a_mag, b_mag;
  logic         swap;
  logic [E:0]   dif;
  logic [F-1:0] sml_ext, lost_mask, big_sig_d, sml_sig_d;
  logic         sp_d;
  logic [W-1:0] sp_res_d;
  logic [3:0]   sp_flg_d;

  // Subtraction is just addition with input2's sign flipped.
  assign a_w = fp_if.input1;
  assign b_w = fp_if.input2 ^ {fp_if.sub, {(W-1){1'b0}}};

  assign a_s = fp_sign(fp_word_t'(a_w), E, M);
  assign b_s = fp_sign(fp_word_t'(b_w), E, M);
  assign a_e = E'(fp_exp(fp_word_t'(a_w), E, M));
  assign b_e = E'(fp_exp(fp_word_t'(b_w), E, M));
  assign a_f = M'(fp_frac(fp_word_t'(a_w), M));
  assign b_f = M'(fp_frac(fp_word_t'(b_w), M));
  assign a_c = fp_class(fp_word_t'(a_w), E, M);
  assign b_c = fp_class(fp_word_t'(b_w), E, M);

  // Flushed operands compare as zero magnitude.
  assign a_mag = (a_c == ZERO) ? '0 : {a_e, a_f};
  assign b_mag = (b_c == ZERO) ? '0 : {b_e, b_f};
  assign swap  = b_mag > a_mag;

  assign big_w = swap ? b_w : a_w;
  assign big_s = swap ? b_s : a_s;
  assign sml_s = swap ? a_s : b_s;
  assign big_e = swap ? b_e : a_e;
  assign sml_e = swap ? a_e : b_e;
  assign big_f = swap ? b_f : a_f;
  assign sml_f = swap ? a_f : b_f;

  assign dif       = {1'b0, big_e} - {1'b0, sml_e};
  assign big_sig_d = {1'b1, big_f, 3'b000};
  assign sml_ext   = {1'b1, sml_f, 3'b000};
  assign lost_mask = ~({F{1'b1}} << dif);

  // Everything shifted past the sticky position collapses into sticky.
  always_comb begin
    if (int'(dif) >= M + 3) sml_sig_d = F'(1);
    else                    sml_sig_d = (sml_ext >> dif) | F'(|(sml_ext & lost_mask));
  end

  // Results that bypass the arithmetic, in priority order.
  always_comb begin
    sp_d     = 1'b1;
    sp_res_d = '0;
    sp_flg_d = '0;
    if (a_c == NAN || b_c == NAN || (a_c == INF && b_c == INF && a_s != b_s)) begin
      sp_res_d               = QNAN;
      sp_flg_d[FLAG_INVALID] = 1'b1;
    end else if (a_c == INF || b_c == INF) begin
      sp_res_d = big_w;                     // infinity always wins the magnitude swap
    end else if (a_c == ZERO && b_c == ZERO) begin
      sp_res_d = {a_s & b_s, {(W-1){1'b0}}};
    end else if (a_c == ZERO || b_c == ZERO) begin
      sp_res_d = big_w;                     // the non-zero operand is the larger one
    end else begin
      sp_d = 1'b0;
    end
  end

  logic         s1_vld_q, s1_sp_q, s1_sign_q, s1_sml_sign_q;
  logic [W-1:0] s1_sp_res_q;
  logic [3:0]   s1_sp_flg_q;
  logic [E-1:0] s1_exp_q;
  logic [F-1:0] s1_big_q, s1_sml_q;

  // ---------------- stage 2: magnitude add / subtract ----------------
  logic [F:0]   sum_d;
  assign sum_d = (s1_sign_q ^ s1_sml_sign_q) ? ({1'b0, s1_big_q} - {1'b0, s1_sml_q})
                                             : ({1'b0, s1_big_q} + {1'b0, s1_sml_q});

  logic         s2_vld_q, s2_sp_q, s2_sign_q;
  logic [W-1:0] s2_sp_res_q;
  logic [3:0]   s2_sp_flg_q;
  logic [E-1:0] s2_exp_q;
  logic [F:0]   s2_sum_q;

  // ---------------- stage 3: normalise, round, pack ----------------
  logic [LZW-1:0] lz;
  logic [F-1:0]   norm;
  logic [M+1:0]   mant;
  logic           rnd_inc;
  int             exp_n, exp_r;
  logic [W-1:0]   res_d;
  logic [3:0]     flg_d;

  fp_lzc #(.WIDTH(F)) u_lzc (
    .vec_i (s2_sum_q[F-1:0]),
    .cnt_o (lz)
  );

  always_comb begin
    if (s2_sum_q[F]) begin
      norm  = {s2_sum_q[F:2], s2_sum_q[1] | s2_sum_q[0]};
      exp_n = int'(s2_exp_q) + 1;
    end else begin
      norm  = s2_sum_q[F-1:0] << lz;
      exp_n = int'(s2_exp_q) - int'(lz);
    end
    // norm[3] = lsb, [2] = guard, [1] = round, [0] = sticky
    rnd_inc = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant    = {1'b0, norm[F-1:3]} + (M+2)'(rnd_inc);
    exp_r   = exp_n + int'(mant[M+1]);

    res_d = '0;
    flg_d = '0;
    if (s2_sp_q) begin
      res_d = s2_sp_res_q;
      flg_d = s2_sp_flg_q;
    end else if (s2_sum_q == '0) begin
      res_d = '0;                           // exact cancellation gives +0
    end else if (exp_r >= EMAX) begin
      res_d                   = {s2_sign_q, {E{1'b1}}, {M{1'b0}}};
      flg_d[FLAG_OVERFLOW]    = 1'b1;
      flg_d[FLAG_INEXACT]     = 1'b1;
    end else if (exp_r <= 0) begin
      res_d                   = {s2_sign_q, {(W-1){1'b0}}};
      flg_d[FLAG_UNDERFLOW]   = 1'b1;
      flg_d[FLAG_INEXACT]     = 1'b1;
    end else begin
      res_d               = {s2_sign_q, E'(exp_r), mant[M+1] ? mant[M:1] : mant[M-1:0]};
      flg_d[FLAG_INEXACT] = norm[2] | norm[1] | norm[0];
    end
  end

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q    <= 1'b0;
      s2_vld_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      flags_q     <= '0;
    end else if (adv) begin
      s1_vld_q    <= fp_if.in_valid;
      s2_vld_q    <= s1_vld_q;
      out_valid_q <= s2_vld_q;
      out_q       <= res_d;
      flags_q     <= flg_d;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      s1_sp_q       <= sp_d;
      s1_sp_res_q   <= sp_res_d;
      s1_sp_flg_q   <= sp_flg_d;
      s1_sign_q     <= big_s;
      s1_sml_sign_q <= sml_s;
      s1_exp_q      <= big_e;
      s1_big_q      <= big_sig_d;
      s1_sml_q      <= sml_sig_d;
      s2_sp_q       <= s1_sp_q;
      s2_sp_res_q   <= s1_sp_res_q;
      s2_sp_flg_q   <= s1_sp_flg_q;
      s2_sign_q     <= s1_sign_q;
      s2_exp_q      <= s1_exp_q;
      s2_sum_q      <= sum_d;
    end
  end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed bench for fp_addsub_pipe: single and half precision instances.
module tb_fp_addsub_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_addsub_pipe_if #(.exponent(8), .mantissa(23)) s_if ();
  fp_addsub_pipe_if #(.exponent(5), .mantissa(10)) h_if ();

  fp_addsub_pipe #(.exponent(8), .mantissa(23)) dut_s (.clk(clk), .rst(rst), .fp_if(s_if));
  fp_addsub_pipe #(.exponent(5), .mantissa(10)) dut_h (.clk(clk), .rst(rst), .fp_if(h_if));

  int checks   = 0;
  int failures = 0;
  int idx, rcv;

  logic [31:0] bp_a   [6] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                              32'h40800000, 32'h40A00000, 32'h40C00000};
  logic [31:0] bp_exp [6] = '{32'h40000000, 32'h40400000, 32'h40800000,
                              32'h40A00000, 32'h40C00000, 32'h40E00000};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One operation through an otherwise idle pipe; checks latency, result and flags.
  task automatic run_op(input bit half, input logic [31:0] a, input logic [31:0] b,
                        input bit s, input logic [31:0] exp_out, input logic [3:0] exp_flg,
                        input string tag);
    int n;
    @(posedge clk); #1;
    if (half) begin
      h_if.in_valid = 1'b1; h_if.input1 = a[15:0]; h_if.input2 = b[15:0]; h_if.sub = s;
    end else begin
      s_if.in_valid = 1'b1; s_if.input1 = a; s_if.input2 = b; s_if.sub = s;
    end
    @(posedge clk); #1;
    n = 1;
    s_if.in_valid = 1'b0;
    h_if.in_valid = 1'b0;
    while (!(half ? h_if.out_valid : s_if.out_valid) && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'd3);
    chk({tag, "_out"}, half ? {48'h0, h_if.out} : {32'h0, s_if.out}, {32'h0, exp_out});
    chk({tag, "_flags"}, half ? {60'h0, h_if.flags} : {60'h0, s_if.flags}, {60'h0, exp_flg});
  endtask

  initial begin
    rst = 1'b1;
    s_if.in_valid = 1'b0; s_if.input1 = '0; s_if.input2 = '0; s_if.sub = 1'b0; s_if.out_ready = 1'b1;
    h_if.in_valid = 1'b0; h_if.input1 = '0; h_if.input2 = '0; h_if.sub = 1'b0; h_if.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'h0, s_if.out_valid}, 64'd0);
    chk("rst_out",       {32'h0, s_if.out},       64'd0);
    chk("rst_flags",     {60'h0, s_if.flags},     64'd0);
    chk("rst_in_ready",  {63'h0, s_if.in_ready},  64'd0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready",  {63'h0, s_if.in_ready},  64'd1);

    run_op(0, 32'h3F800000, 32'h3F800000, 0, 32'h40000000, 4'b0000, "add_1p1");
    run_op(0, 32'h3F800000, 32'h33800000, 0, 32'h3F800000, 4'b0001, "tie_even_down");
    run_op(0, 32'h3F800001, 32'h33800000, 0, 32'h3F800002, 4'b0001, "tie_even_up");
    run_op(0, 32'h40000000, 32'h3F800000, 1, 32'h3F800000, 4'b0000, "sub_2m1");
    run_op(0, 32'h3FC00000, 32'h3FC00000, 1, 32'h00000000, 4'b0000, "cancel");
    run_op(0, 32'h80000000, 32'h80000000, 0, 32'h80000000, 4'b0000, "negzero");
    run_op(0, 32'h7F800000, 32'hFF800000, 0, 32'h7FC00000, 4'b1000, "inf_minus_inf");
    run_op(0, 32'h7F7FFFFF, 32'h7F7FFFFF, 0, 32'h7F800000, 4'b0101, "overflow");
    run_op(0, 32'h00400000, 32'h00000000, 0, 32'h00000000, 4'b0000, "subnormal_flush");
    run_op(0, 32'h00800000, 32'h00C00000, 1, 32'h80000000, 4'b0011, "underflow");
    run_op(1, 32'h00003C00, 32'h00003C00, 0, 32'h00004000, 4'b0000, "half_add");

    // Six back-to-back adds with the consumer stalled for cycles 4..8.
    idx = 0;
    rcv = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      s_if.in_valid  = (idx < 6);
      s_if.input1    = bp_a[(idx < 6) ? idx : 5];
      s_if.input2    = 32'h3F800000;
      s_if.sub       = 1'b0;
      s_if.out_ready = !(c >= 4 && c <= 8);
      @(negedge clk);
      if (c >= 4 && c <= 8) begin
        chk("bp_stall_in_ready", {63'h0, s_if.in_ready},  64'd0);
        chk("bp_stall_valid",    {63'h0, s_if.out_valid}, 64'd1);
        chk("bp_stall_out",      {32'h0, s_if.out},       64'h40400000);
      end
      if (s_if.out_valid && s_if.out_ready) begin
        if (rcv < 6) chk("bp_order", {32'h0, s_if.out}, {32'h0, bp_exp[rcv]});
        rcv++;
      end
      if (s_if.in_valid && s_if.in_ready) idx++;
    end
    s_if.in_valid  = 1'b0;
    s_if.out_ready = 1'b1;
    chk("bp_sent", 64'(idx), 64'd6);
    chk("bp_rcvd", 64'(rcv), 64'd6);

    // Reset with two operations in flight: nothing may come out afterwards.
    @(posedge clk); #1;
    s_if.in_valid = 1'b1; s_if.input1 = 32'h3F800000; s_if.input2 = 32'h3F800000; s_if.sub = 1'b0;
    @(posedge clk); #1;
    s_if.input1 = 32'h40000000;
    @(posedge clk); #1;
    s_if.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_hi_in_ready", {63'h0, s_if.in_ready}, 64'd0);
    @(posedge clk); #1;
    chk("rst_flush_valid", {63'h0, s_if.out_valid}, 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("rst_no_stale", {63'h0, s_if.out_valid}, 64'd0);
    end
    chk("rst_after_in_ready", {63'h0, s_if.in_ready}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
